// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the FIFO word packer.
// Holds the packer state encoding, default geometry and the lane keep-mask builder.
package fifo_pack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2
    } pack_state_t;

    localparam int DEFAULT_FIFO_WIDTH = 16;
    localparam int DEFAULT_PACK_RATIO = 2;
    localparam int MAX_PACK_RATIO     = 8;

    // Low 'count' bits set; callers slice down to their own lane count.
    function automatic logic [MAX_PACK_RATIO-1:0] keep_mask(input int unsigned count);
        logic [MAX_PACK_RATIO-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_PACK_RATIO; i++) begin
            if (i < count) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops FIFO words one at a time and packs PACK_RATIO of them into one wide beat.
// A flush emits whatever lanes are filled, with m_keep marking the valid ones.
module fifo_word_packer
    import fifo_pack_pkg::*;
#(
    parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
    parameter int PACK_RATIO = DEFAULT_PACK_RATIO
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fifo_empty,
    input  logic [FIFO_WIDTH-1:0]            fifo_data_out,
    output logic                             fifo_rd_en,
    input  logic                             flush,
    output logic [FIFO_WIDTH*PACK_RATIO-1:0] m_data,
    output logic [PACK_RATIO-1:0]            m_keep,
    output logic                             m_valid,
    input  logic                             m_ready
);

    localparam int CW = $clog2(PACK_RATIO + 1);
    localparam logic [CW-1:0] LAST_LANE = CW'(PACK_RATIO - 1);
    localparam logic [CW:0]   RATIO_W   = (CW+1)'(PACK_RATIO);

    pack_state_t           state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic                  pend_reg, pend_next;
    logic                  flush_req_reg, flush_req_next;
    logic                  m_valid_reg, m_valid_next;
    logic [PACK_RATIO-1:0] m_keep_reg, m_keep_next;

    logic                      capture;
    logic                      beat_done;
    logic [CW:0]               inflight;
    logic [MAX_PACK_RATIO-1:0] cnt_mask;

    // Words already captured plus the one still in flight from the FIFO.
    assign inflight  = {1'b0, cnt_reg} + {{CW{1'b0}}, pend_reg};
    assign capture   = (state_reg == FILL) && pend_reg;
    assign beat_done = (state_reg == OUT) && m_valid_reg && m_ready;
    assign cnt_mask  = keep_mask({{(32-CW){1'b0}}, cnt_reg});

    assign fifo_rd_en = (state_reg == FILL) && !fifo_empty && !flush_req_reg
                        && (inflight < RATIO_W);

    assign m_valid = m_valid_reg;
    assign m_keep  = m_keep_reg;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_next      = 1'b0;
        flush_req_next = flush_req_reg;
        m_valid_next   = m_valid_reg;
        m_keep_next    = m_keep_reg;

        case (state_reg)
            IDLE: begin
                state_next = FILL;
            end

            FILL: begin
                pend_next      = fifo_rd_en;
                flush_req_next = flush_req_reg | flush;
                if (capture) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == LAST_LANE) begin
                        state_next   = OUT;
                        m_valid_next = 1'b1;
                        m_keep_next  = {PACK_RATIO{1'b1}};
                    end
                end else if (flush_req_reg) begin
                    if (cnt_reg != '0) begin
                        state_next   = OUT;
                        m_valid_next = 1'b1;
                        m_keep_next  = cnt_mask[PACK_RATIO-1:0];
                    end else begin
                        // Nothing captured and nothing in flight: no beat to emit.
                        flush_req_next = 1'b0;
                    end
                end
            end

            OUT: begin
                if (beat_done) begin
                    state_next     = FILL;
                    cnt_next       = '0;
                    flush_req_next = 1'b0;
                    m_valid_next   = 1'b0;
                    m_keep_next    = '0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pend_reg      <= 1'b0;
            flush_req_reg <= 1'b0;
            m_valid_reg   <= 1'b0;
            m_keep_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_reg      <= pend_next;
            flush_req_reg <= flush_req_next;
            m_valid_reg   <= m_valid_next;
            m_keep_reg    <= m_keep_next;
        end
    end

    // Lanes are cleared after every beat so unfilled lanes of a partial beat read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
            logic [FIFO_WIDTH-1:0] lane_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (beat_done) begin
                    lane_reg <= '0;
                end else if (capture && (cnt_reg == CW'(gi))) begin
                    lane_reg <= fifo_data_out;
                end
            end

            assign m_data[gi*FIFO_WIDTH +: FIFO_WIDTH] = lane_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a 2-lane and a 4-lane instance, each fed by a queue-based FIFO model.
// Expected beats are queued as words are loaded and checked when the packer presents them.
module tb_fifo_word_packer;

    logic clk;
    logic rst_n;
    logic flush;
    logic m_ready;

    logic        e2, rd2, mv2;
    logic [15:0] dout2;
    logic [31:0] md2;
    logic [1:0]  mk2;

    logic        e4, rd4, mv4;
    logic [15:0] dout4;
    logic [63:0] md4;
    logic [3:0]  mk4;

    logic [15:0] q2[$];
    logic [15:0] q4[$];
    logic [63:0] exp_data[$];
    logic [7:0]  exp_keep[$];

    logic uf2 = 1'b0;
    logic uf4 = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    fifo_word_packer #(.FIFO_WIDTH(16), .PACK_RATIO(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(e2), .fifo_data_out(dout2),
        .fifo_rd_en(rd2), .flush(flush), .m_data(md2), .m_keep(mk2),
        .m_valid(mv2), .m_ready(m_ready)
    );

    fifo_word_packer #(.FIFO_WIDTH(16), .PACK_RATIO(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(e4), .fifo_data_out(dout4),
        .fifo_rd_en(rd4), .flush(flush), .m_data(md4), .m_keep(mk4),
        .m_valid(mv4), .m_ready(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: one-cycle read latency, underflow flagged if popped while empty.
    assign e2 = (q2.size() == 0);
    assign e4 = (q4.size() == 0);

    always @(posedge clk) begin
        if (rd2 && e2) uf2 <= 1'b1;
        if (rd2 && !e2) begin
            dout2 <= q2[0];
            q2.delete(0);
        end
    end

    always @(posedge clk) begin
        if (rd4 && e4) uf4 <= 1'b1;
        if (rd4 && !e4) begin
            dout4 <= q4[0];
            q4.delete(0);
        end
    end

    task automatic wait_beat(input int which, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 2 && mv2) || (which == 4 && mv4)) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (mv2 !== 1'b0) begin miscompares++; $display("FAIL reset_valid2 got=%b want=0", mv2); end
        vectors++; if (mk2 !== 2'b00) begin miscompares++; $display("FAIL reset_keep2 got=%b want=00", mk2); end
        vectors++; if (md2 !== 32'h0) begin miscompares++; $display("FAIL reset_data2 got=%h want=0", md2); end
        vectors++; if (rd2 !== 1'b0) begin miscompares++; $display("FAIL reset_rd2 got=%b want=0", rd2); end
        vectors++; if (mv4 !== 1'b0) begin miscompares++; $display("FAIL reset_valid4 got=%b want=0", mv4); end
        vectors++; if (md4 !== 64'h0) begin miscompares++; $display("FAIL reset_data4 got=%h want=0", md4); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: released");
    endtask

    task automatic test_full_group();
        bit got;
        m_ready = 1'b1;
        q2.push_back(16'h1111);
        q2.push_back(16'h2222);
        exp_data.push_back(64'h0000_0000_2222_1111);
        exp_keep.push_back(8'h03);
        wait_beat(2, 20, got);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL full_timeout got=no_beat want=beat");
        end else begin
            vectors++; if (md2 !== exp_data[0][31:0]) begin miscompares++; $display("FAIL full_data got=%h want=%h", md2, exp_data[0][31:0]); end
            vectors++; if (mk2 !== exp_keep[0][1:0]) begin miscompares++; $display("FAIL full_keep got=%b want=%b", mk2, exp_keep[0][1:0]); end
        end
        exp_data.pop_front(); exp_keep.pop_front();
        @(negedge clk);
        vectors++; if (mv2 !== 1'b0) begin miscompares++; $display("FAIL full_valid_width got=%b want=0", mv2); end
        $display("full_group: beat %h keep %b", md2, mk2);
    endtask

    task automatic test_backpressure();
        bit got;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) q2.push_back(16'h00A0 + 16'(i));
        exp_data.push_back(64'h0000_0000_00A1_00A0); exp_keep.push_back(8'h03);
        exp_data.push_back(64'h0000_0000_00A3_00A2); exp_keep.push_back(8'h03);
        wait_beat(2, 20, got);
        vectors++;
        if (!got) begin miscompares++; $display("FAIL bp_timeout got=no_beat want=beat"); end
        for (int c = 0; c < 5; c++) begin
            vectors++; if (mv2 !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", c, mv2); end
            vectors++; if (md2 !== exp_data[0][31:0]) begin miscompares++; $display("FAIL bp_hold_data cyc=%0d got=%h want=%h", c, md2, exp_data[0][31:0]); end
            vectors++; if (rd2 !== 1'b0) begin miscompares++; $display("FAIL bp_rd_en cyc=%0d got=%b want=0", c, rd2); end
            @(negedge clk);
        end
        exp_data.pop_front(); exp_keep.pop_front();
        m_ready = 1'b1;
        wait_beat(2, 20, got);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL bp_second_timeout got=no_beat want=beat");
        end else begin
            vectors++; if (md2 !== exp_data[0][31:0]) begin miscompares++; $display("FAIL bp_second_data got=%h want=%h", md2, exp_data[0][31:0]); end
            vectors++; if (mk2 !== exp_keep[0][1:0]) begin miscompares++; $display("FAIL bp_second_keep got=%b want=%b", mk2, exp_keep[0][1:0]); end
        end
        $display("backpressure: second beat %h", md2);
        exp_data.pop_front(); exp_keep.pop_front();
        @(negedge clk);
    endtask

    task automatic test_flush_partial();
        bit got;
        m_ready = 1'b1;
        q2.push_back(16'hBEEF);
        exp_data.push_back(64'h0000_0000_0000_BEEF); exp_keep.push_back(8'h01);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_beat(2, 20, got);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL flush_timeout got=no_beat want=beat");
        end else begin
            vectors++; if (md2 !== exp_data[0][31:0]) begin miscompares++; $display("FAIL flush_data got=%h want=%h", md2, exp_data[0][31:0]); end
            vectors++; if (mk2 !== exp_keep[0][1:0]) begin miscompares++; $display("FAIL flush_keep got=%b want=%b", mk2, exp_keep[0][1:0]); end
        end
        $display("flush_partial: beat %h keep %b", md2, mk2);
        exp_data.pop_front(); exp_keep.pop_front();
        @(negedge clk);
    endtask

    task automatic test_flush_empty();
        bit got;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vectors++; if (mv2 !== 1'b0) begin miscompares++; $display("FAIL flush_empty_valid cyc=%0d got=%b want=0", c, mv2); end
            @(negedge clk);
        end
        // A dropped flush must not block the next full group.
        q2.push_back(16'h3333);
        q2.push_back(16'h4444);
        exp_data.push_back(64'h0000_0000_4444_3333); exp_keep.push_back(8'h03);
        wait_beat(2, 20, got);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL flush_empty_next_timeout got=no_beat want=beat");
        end else begin
            vectors++; if (md2 !== exp_data[0][31:0]) begin miscompares++; $display("FAIL flush_empty_next_data got=%h want=%h", md2, exp_data[0][31:0]); end
            vectors++; if (mk2 !== exp_keep[0][1:0]) begin miscompares++; $display("FAIL flush_empty_next_keep got=%b want=%b", mk2, exp_keep[0][1:0]); end
        end
        $display("flush_empty: following beat %h", md2);
        exp_data.pop_front(); exp_keep.pop_front();
        @(negedge clk);
    endtask

    task automatic test_empty_never_popped();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++; if (rd2 !== 1'b0) begin miscompares++; $display("FAIL empty_rd_en cyc=%0d got=%b want=0", c, rd2); end
        end
        vectors++; if (uf2 !== 1'b0) begin miscompares++; $display("FAIL underflow2 got=%b want=0", uf2); end
        vectors++; if (uf4 !== 1'b0) begin miscompares++; $display("FAIL underflow4 got=%b want=0", uf4); end
        $display("empty_never_popped: 20 idle cycles");
    endtask

    task automatic test_reset_mid_group();
        bit got;
        m_ready = 1'b1;
        q4.push_back(16'h00C0);
        q4.push_back(16'h00C1);
        q4.push_back(16'h00C2);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (mv4 !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got=%b want=0", mv4); end
        vectors++; if (mk4 !== 4'h0) begin miscompares++; $display("FAIL rst_mid_keep got=%b want=0000", mk4); end
        vectors++; if (md4 !== 64'h0) begin miscompares++; $display("FAIL rst_mid_data got=%h want=0", md4); end
        q4.delete();
        for (int i = 0; i < 4; i++) q4.push_back(16'h00D0 + 16'(i));
        exp_data.push_back(64'h00D3_00D2_00D1_00D0); exp_keep.push_back(8'h0F);
        @(negedge clk);
        vectors++; if (rd4 !== 1'b0) begin miscompares++; $display("FAIL rst_mid_rd_in_reset got=%b want=0", rd4); end
        rst_n = 1'b1;
        #1;
        vectors++; if (rd4 !== 1'b0) begin miscompares++; $display("FAIL rst_first_edge_rd got=%b want=0", rd4); end
        wait_beat(4, 30, got);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL rst_mid_timeout got=no_beat want=beat");
        end else begin
            vectors++; if (md4 !== exp_data[0]) begin miscompares++; $display("FAIL rst_mid_beat_data got=%h want=%h", md4, exp_data[0]); end
            vectors++; if (mk4 !== exp_keep[0][3:0]) begin miscompares++; $display("FAIL rst_mid_beat_keep got=%b want=%b", mk4, exp_keep[0][3:0]); end
        end
        $display("reset_mid_group: post-reset beat %h", md4);
        exp_data.pop_front(); exp_keep.pop_front();
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_full_group();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_empty_never_popped();
        test_reset_mid_group();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
